// File: rtl/debounce_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package : debounce_pkg                                                    |
// | Shared debounce timing helpers and the edge type used by consumers.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package debounce_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_t;

  function automatic int db_ticks(input int sim, input int clk_hz, input int ms,
                                  input int sim_ticks);
    if (sim != 0) return sim_ticks;
    return (clk_hz / 1000) * ms;
  endfunction

  // Width that holds DB_TICKS-1, never below one bit.
  function automatic int cnt_width(input int ticks);
    if (ticks <= 2) return 1;
    return $clog2(ticks);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : debounce_channel                                                |
// | One switch: 2-FF synchroniser, stability counter, level and edge pulses.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_TICKS = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW     = cnt_width(DB_TICKS);
  localparam logic [CW-1:0] C_TERM = CW'(DB_TICKS - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_sw;
      r_sync <= r_meta;
      r_db_d <= r_db;
      // Any return to the current level before terminal count restarts the wait.
      if (r_sync != r_db) begin
        if (r_cnt == C_TERM) begin
          r_db  <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_db & ~r_db_d;
  assign o_fall = ~r_db & r_db_d;

endmodule
`default_nettype wire

// File: rtl/switch_debounce_bank.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : switch_debounce_bank                                            |
// | N-channel switch debouncer with rise/fall pulses and any_edge summary.    |
// | Optional sticky change flags: define DEBOUNCE_STICKY_EN.                  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module switch_debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH        = 16,
  parameter int SIMULACION  = 0,
  parameter int CLK_HZ      = 10_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int SIM_TICKS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            any_edge,
  output logic [N_CH-1:0] changed,
  input  logic [N_CH-1:0] changed_clr
);

  localparam int DB_TICKS = db_ticks(SIMULACION, CLK_HZ, DEBOUNCE_MS, SIM_TICKS);

  // Assert immediately, release on the second clock after reset goes high.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .DB_TICKS (DB_TICKS)
    ) u_ch (
      .clk     (clk),
      .i_rst_n (w_rst_n),
      .i_sw    (sw_in[gi]),
      .o_db    (sw_db[gi]),
      .o_rise  (sw_rise[gi]),
      .o_fall  (sw_fall[gi])
    );
  end

  assign any_edge = |(sw_rise | sw_fall);

`ifdef DEBOUNCE_STICKY_EN
  logic [N_CH-1:0] r_changed;

  // Set is ORed in after the clear so a coincident event keeps the flag.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_changed <= '0;
    end else begin
      r_changed <= (r_changed & ~changed_clr) | sw_rise | sw_fall;
    end
  end

  assign changed = r_changed;
`else
  logic w_unused_clr;

  assign changed      = '0;
  assign w_unused_clr = ^changed_clr;
`endif

endmodule
`default_nettype wire
